// File: rtl/cache_pkg.sv
// Shared types and helpers for the way victim selector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    typedef enum logic {
        REPL_PLRU = 1'b0,
        REPL_RR   = 1'b1
    } repl_mode_e;

    // Index width that never collapses to zero, so a single-set cache still has a set port.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/way_victim_selector_plru_tree.sv
// Tree pseudo-LRU helper: victim lookup and access update for one set's node bits.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module plru_tree #(
    parameter int N_WAYS = 4
) (
    input  logic [N_WAYS-2:0]         i_node_bits,
    input  logic [$clog2(N_WAYS)-1:0] i_access_way,
    output logic [$clog2(N_WAYS)-1:0] o_victim_way,
    output logic [N_WAYS-2:0]         o_next_bits
);
    localparam int WAY_W   = $clog2(N_WAYS);
    localparam int N_NODES = N_WAYS - 1;

    // Walk from the root following each node bit; the bits taken spell the victim MSB first.
    always_comb begin : victim_walk
        int   node;
        logic b;
        node         = 0;
        b            = 1'b0;
        o_victim_way = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int n = 0; n < N_NODES; n++) begin
                if (n == node) b = i_node_bits[n];
            end
            o_victim_way[WAY_W-1-l] = b;
            node = 2 * node + 1 + int'(b);
        end
    end

    // Walk the access way's path and flip every node on it to point at the other subtree.
    always_comb begin : access_update
        int   node;
        logic dir;
        node        = 0;
        dir         = 1'b0;
        o_next_bits = i_node_bits;
        for (int l = 0; l < WAY_W; l++) begin
            dir = i_access_way[WAY_W-1-l];
            for (int n = 0; n < N_NODES; n++) begin
                if (n == node) o_next_bits[n] = ~dir;
            end
            node = 2 * node + 1 + int'(dir);
        end
    end

endmodule

// File: rtl/way_victim_selector.sv
// Picks the fill way for each allocation request; flags eviction when the set is full.
// Latency: 1 cycle from alloc_req to alloc_ack, one result per cycle.
// Backpressure: none, a request is accepted every cycle and never stalled.
module way_victim_selector
    import cache_pkg::*;
#(
    parameter int N_WAYS    = 4,
    parameter int N_SETS    = 16,
    parameter int REPL_MODE = 0,
    localparam int WAY_W    = $clog2(N_WAYS),
    localparam int SET_W    = clog2_min1(N_SETS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    input  logic [SET_W-1:0]  alloc_set,
    input  logic [N_WAYS-1:0] valid_ways,
    input  logic              touch_en,
    input  logic [SET_W-1:0]  touch_set,
    input  logic [WAY_W-1:0]  touch_way,
    output logic              alloc_ack,
    output logic [WAY_W-1:0]  alloc_way,
    output logic              alloc_evict
);
    localparam int N_NODES = N_WAYS - 1;
    localparam bit IS_RR   = (REPL_MODE == int'(REPL_RR));
    localparam bit ONE_SET = (N_SETS == 1);

    logic [N_NODES-1:0] r_plru   [N_SETS];
    logic [WAY_W-1:0]   r_rr_ptr [N_SETS];
    logic               r_ack;
    logic [WAY_W-1:0]   r_way;
    logic               r_evict;

    logic [SET_W-1:0]   w_alloc_idx;
    logic [SET_W-1:0]   w_touch_idx;
    logic               w_all_valid;
    logic [WAY_W-1:0]   w_free_way;
    logic [WAY_W-1:0]   w_plru_victim;
    logic [WAY_W-1:0]   w_alloc_way;
    logic [N_NODES-1:0] w_alloc_next;
    logic [N_NODES-1:0] w_touch_next;
    logic [WAY_W-1:0]   w_unused_touch_victim;
    logic               w_touch_wr;

    // A single-set cache only has entry 0; any other index folds onto it.
    assign w_alloc_idx = ONE_SET ? '0 : alloc_set;
    assign w_touch_idx = ONE_SET ? '0 : touch_set;
    assign w_all_valid = &valid_ways;

    // Lowest-index invalid way; scanning downward lets the lowest one win.
    always_comb begin
        w_free_way = '0;
        for (int i = N_WAYS - 1; i >= 0; i--) begin
            if (!valid_ways[i]) w_free_way = WAY_W'(i);
        end
    end

    plru_tree #(.N_WAYS(N_WAYS)) u_alloc_tree (
        .i_node_bits  (r_plru[w_alloc_idx]),
        .i_access_way (w_alloc_way),
        .o_victim_way (w_plru_victim),
        .o_next_bits  (w_alloc_next)
    );

    plru_tree #(.N_WAYS(N_WAYS)) u_touch_tree (
        .i_node_bits  (r_plru[w_touch_idx]),
        .i_access_way (touch_way),
        .o_victim_way (w_unused_touch_victim),
        .o_next_bits  (w_touch_next)
    );

    assign w_alloc_way = !w_all_valid ? w_free_way
                       : (IS_RR ? r_rr_ptr[w_alloc_idx] : w_plru_victim);

    // An allocation to the same set takes priority, so the colliding touch is dropped.
    assign w_touch_wr = touch_en && !IS_RR && !(alloc_req && (w_touch_idx == w_alloc_idx));

    // Result registers and per-set replacement state; reset overrides any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_way   <= '0;
            r_evict <= 1'b0;
            for (int s = 0; s < N_SETS; s++) begin
                r_plru[s]   <= '0;
                r_rr_ptr[s] <= '0;
            end
        end else begin
            r_ack <= alloc_req;
            if (alloc_req) begin
                r_way   <= w_alloc_way;
                r_evict <= w_all_valid;
            end
            if (w_touch_wr) begin
                r_plru[w_touch_idx] <= w_touch_next;
            end
            if (alloc_req) begin
                if (!IS_RR) begin
                    r_plru[w_alloc_idx] <= w_alloc_next;
                end else if (w_all_valid) begin
                    r_rr_ptr[w_alloc_idx] <= r_rr_ptr[w_alloc_idx] + WAY_W'(1);
                end
            end
        end
    end

    assign alloc_ack   = r_ack;
    assign alloc_way   = r_way;
    assign alloc_evict = r_evict;

endmodule
